id_inst_queue: RTL

//   Parametrised instruction queue between the IF stage and ID decode.

---
 rtl/id_inst_queue.sv | 110 +++++++++++
 1 files changed

// File: rtl/id_inst_queue.sv
// Instruction queue between IF and ID: buffers {addr, inst} pairs and flushes on a taken branch.
// Define ID_QUEUE_BYPASS_EN to let an empty queue pass IF straight through to ID in the same cycle.
module id_inst_queue #(
    parameter int ADDR_W     = 32,
    parameter int INST_W     = 32,
    parameter int DEPTH      = 4,
    parameter int DELAY_SLOT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       if_valid,
    input  logic [ADDR_W-1:0]          if_addr,
    input  logic [INST_W-1:0]          if_inst,
    output logic                       if_ready,
    output logic                       id_valid,
    output logic [ADDR_W-1:0]          id_addr,
    output logic [INST_W-1:0]          id_inst,
    input  logic                       id_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int ENT_W = ADDR_W + INST_W;

    logic [ENT_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt, rd_adv;
    logic [CNT_W-1:0] count_q, count_nxt, survivors;
    logic             push, pop, q_pop, byp_pop, store, mem_we, bypass;
    logic [ENT_W-1:0] head;

`ifdef ID_QUEUE_BYPASS_EN
    // Gated by rst so outputs still reach their reset values asynchronously.
    assign bypass = rst & if_valid & (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    // if_ready depends only on registered state, so a full queue never accepts
    // a push even when ID pops in the same cycle.
    assign if_ready = (count_q < CNT_W'(DEPTH));
    assign id_valid = (count_q != '0) | bypass;
    assign push     = if_valid & if_ready;
    assign pop      = id_valid & id_ready;
    assign byp_pop  = pop & bypass;
    assign q_pop    = pop & ~bypass;
    assign store    = push & ~byp_pop;

    assign head    = bypass ? {if_addr, if_inst} : mem[rd_ptr];
    assign id_addr = id_valid ? head[ENT_W-1:INST_W] : '0;
    assign id_inst = id_valid ? head[INST_W-1:0]     : '0;
    assign count   = count_q;

    assign rd_adv    = q_pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    assign survivors = count_q - CNT_W'(q_pop);

    // Flush acts on what is left after this cycle's pop. With a delay slot the
    // oldest survivor is kept; failing that, the same-cycle push becomes the slot.
    always_comb begin
        rd_ptr_nxt = rd_ptr;
        wr_ptr_nxt = wr_ptr;
        count_nxt  = count_q;
        mem_we     = 1'b0;
        if (flush) begin
            if (DELAY_SLOT != 0 && survivors != '0) begin
                rd_ptr_nxt = rd_adv;
                wr_ptr_nxt = rd_adv + PTR_W'(1);
                count_nxt  = CNT_W'(1);
            end else if (DELAY_SLOT != 0 && store) begin
                mem_we     = 1'b1;
                rd_ptr_nxt = wr_ptr;
                wr_ptr_nxt = wr_ptr + PTR_W'(1);
                count_nxt  = CNT_W'(1);
            end else begin
                rd_ptr_nxt = wr_ptr;
                count_nxt  = '0;
            end
        end else begin
            mem_we     = store;
            rd_ptr_nxt = rd_adv;
            if (store) begin
                wr_ptr_nxt = wr_ptr + PTR_W'(1);
            end
            count_nxt = count_q + CNT_W'(store) - CNT_W'(q_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            count_q <= count_nxt;
        end
    end

    // Storage is deliberately left out of reset; count gates every read.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr] <= {if_addr, if_inst};
        end
    end

endmodule
